addsub_slice_seq: RTL and testbench

//  Multi-cycle WIDTH-bit adder/subtractor controller. Sits directly upstream of the partial-full-adder (PFA) add/sub

---
 rtl/addsub_slice_seq_if.sv | 26 ++
 rtl/addsub_slice_seq.sv | 124 ++++++++++++
 tb/tb_addsub_slice_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/addsub_slice_seq_if.sv
// Handshake and data bus between the ALU sequencer (master) and the slice-serial add/sub controller (slave).
// Master drives start, sub_sel, a and b. Slave returns ready, done, result, cout, overflow and zero.
interface addsub_slice_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub_sel, a, b,
    input  ready, done, result, cout, overflow, zero
  );

  modport slave (
    input  start, sub_sel, a, b,
    output ready, done, result, cout, overflow, zero
  );
endinterface

// File: rtl/addsub_slice_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one SLICE-wide PFA row, processing one slice per cycle.
// Latency: done pulses NSLICE edges after the accept edge; one op every NSLICE+2 cycles.
// Backpressure: ready is high only in IDLE; start while busy is ignored, with no queuing.
// Ports: clk_i (rising edge), rst_i (synchronous, active high), bus (slave side of addsub_slice_seq_if).
module addsub_slice_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  addsub_slice_seq_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     k_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              sub_q;
  logic              carry_q;
  logic [WIDTH-1:0]  result_q;
  logic              cout_q;
  logic              ovf_q;
  logic              done_q;

  logic [SLICE-1:0]  a_sl;
  logic [SLICE-1:0]  b_sl;
  logic [SLICE-1:0]  pfa_s;
  logic [SLICE-1:0]  pfa_p;
  logic [SLICE-1:0]  pfa_g_n;
  logic [SLICE:0]    c;
  logic [SLICE-1:0]  slice_d;
  logic              carry_d;
  logic              ovf_d;
  logic              last_slice;

  assign a_sl       = a_q[k_q*SLICE +: SLICE];
  assign b_sl       = b_q[k_q*SLICE +: SLICE];
  assign last_slice = (k_q == CW'(NSLICE - 1));

  // PFA row plus lookahead carry chain. In subtract mode the cells invert b,
  // and the +1 of two's complement comes in through carry_q, which is seeded
  // with sub_sel on the accept edge.
  always_comb begin
    pfa_s   = '0;
    pfa_p   = '0;
    pfa_g_n = '0;
    c       = '0;
    c[0]    = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      pfa_p[i]   = a_sl[i] ^ (b_sl[i] ^ sub_q);
      pfa_g_n[i] = ~(a_sl[i] & (b_sl[i] ^ sub_q));
      pfa_s[i]   = pfa_p[i] ^ c[i];
      c[i+1]     = ~pfa_g_n[i] | (pfa_p[i] & c[i]);
    end
    slice_d = pfa_s;
    carry_d = c[SLICE];
    // On the top slice, c[SLICE-1] is the carry into the operand MSB.
    ovf_d   = c[SLICE-1] ^ c[SLICE];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= bus.sub_sel;
            carry_q <= bus.sub_sel;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // result is rewritten slice by slice, so it is only meaningful once done fires.
          result_q[k_q*SLICE +: SLICE] <= slice_d;
          carry_q <= carry_d;
          k_q     <= k_q + CW'(1);
          if (last_slice) begin
            cout_q  <= carry_d;
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = (result_q == '0);

endmodule

// File: tb/tb_addsub_slice_seq.sv
module tb_addsub_slice_seq;

  localparam int W      = 16;
  localparam int SL     = 4;
  localparam int NSLICE = W / SL;
  localparam int NRAND  = 10000;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   busy_until = 0;
  int   last_acc = -1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  addsub_slice_seq_if #(.WIDTH(W)) bus ();

  addsub_slice_seq #(.WIDTH(W), .SLICE(SL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain two's-complement arithmetic and sign-rule overflow.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t     e;
    int       full;
    full  = s ? (int'(x) + (65536 - int'(y))) : (int'(x) + int'(y));
    e.res = full[W-1:0];
    e.c   = full[W];
    if (s) e.v = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
    else   e.v = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
    e.z   = (e.res == '0);
    e.cyc = 0;
    return e;
  endfunction

  // Called at a negedge where start=1 and ready=1: the next posedge accepts.
  task automatic push_exp(input exp_t e);
    exp_t t;
    t          = e;
    t.cyc      = cyc + 1 + NSLICE;
    busy_until = cyc + 1 + NSLICE;
    sb.push_back(t);
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                       input logic [W-1:0] er, input logic ec, input logic ev);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ia; bus.b = ib; bus.sub_sel = isub;
    while (!bus.ready && t < 20) begin @(negedge clk); t++; end
    if (!bus.ready) begin
      chk("accept_timeout", 32'(bus.ready), 32'd1);
    end else begin
      e.res = er; e.c = ec; e.v = ev; e.z = (er == '0); e.cyc = 0;
      push_exp(e);
    end
    @(negedge clk);
    // Operands scrambled after accept: the DUT must use its latched copies.
    bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.sub_sel = 1'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || !bus.ready) && t < 50) begin @(negedge clk); t++; end
    if (sb.size() != 0 || !bus.ready) chk("idle_timeout", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: ready and done checked every cycle against the bench's own timing model.
  always @(posedge clk) begin
    logic exp_done;
    exp_t e;
    #1;
    chk("ready", 32'(bus.ready), 32'(cyc > busy_until));
    exp_done = (sb.size() != 0) && (sb[0].cyc == cyc);
    chk("done", 32'(bus.done), 32'(exp_done));
    if (exp_done) begin
      e = sb.pop_front();
      chk("result",   32'(bus.result),   32'(e.res));
      chk("cout",     32'(bus.cout),     32'(e.c));
      chk("overflow", 32'(bus.overflow), 32'(e.v));
      chk("zero",     32'(bus.zero),     32'(e.z));
    end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
      void'(sb.pop_front());
    end
  end

  initial begin
    int   t;
    exp_t e;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sub_sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready",  32'(bus.ready),    32'd1);
    chk("rst_done",   32'(bus.done),     32'd0);
    chk("rst_result", 32'(bus.result),   32'd0);
    chk("rst_zero",   32'(bus.zero),     32'd1);
    chk("rst_cout",   32'(bus.cout),     32'd0);
    chk("rst_ovf",    32'(bus.overflow), 32'd0);

    // Directed arithmetic cases with hand-computed expectations.
    issue(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0); wait_idle();
    issue(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0); wait_idle();
    issue(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1); wait_idle();
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1); wait_idle();
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); wait_idle();
    issue(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0); wait_idle();

    // Second start two cycles after accept must be ignored.
    issue(16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_ready", 32'(bus.ready), 32'd0);
    bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555; bus.sub_sel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Reset in the second RUN cycle, together with start: reset wins, op discarded.
    issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1;
    sb.delete();
    busy_until = 0;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    chk("midrst_ready",  32'(bus.ready),  32'd1);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_zero",   32'(bus.zero),   32'd1);
    chk("midrst_done",   32'(bus.done),   32'd0);
    repeat (NSLICE + 2) @(negedge clk);
    issue(16'h4321, 16'h1234, 1'b1, 16'h30ED, 1'b1, 1'b0); wait_idle();

    // Back-to-back random ops with start held high.
    last_acc = -1;
    bus.a = rand_op(); bus.b = rand_op(); bus.sub_sel = 1'($urandom);
    bus.start = 1'b1;
    for (int n = 0; n < NRAND; n++) begin
      t = 0;
      while (!bus.ready && t < 20) begin @(negedge clk); t++; end
      if (!bus.ready) begin
        chk("rand_accept_timeout", 32'(bus.ready), 32'd1);
        break;
      end
      if (last_acc >= 0) chk("accept_spacing", 32'(cyc + 1 - last_acc), 32'(NSLICE + 2));
      last_acc = cyc + 1;
      e = model(bus.a, bus.b, bus.sub_sel);
      push_exp(e);
      @(negedge clk);
      bus.a = rand_op(); bus.b = rand_op(); bus.sub_sel = 1'($urandom);
    end
    bus.start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
